// File: rtl/mc_b_sched.sv
// Round-robin write scheduler for a small MC_B-style bank: arbitrates two writers,
// drives the IncB/WEB/DataInB control encoding and mirrors bank address and fill level.
module mc_b_sched #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          Reset,
    input  logic          ReqA,
    input  logic [DW-1:0] DataA,
    input  logic          ReqB,
    input  logic [DW-1:0] DataB,
    input  logic          Flush,
    output logic          GntA,
    output logic          GntB,
    output logic          IncB,
    output logic          WEB,
    output logic [DW-1:0] DataInB,
    output logic [AW-1:0] AddrMirror,
    output logic [CW-1:0] Count,
    output logic          Full,
    output logic          Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_last_b;
    logic          w_pick_a;

    logic          w_last_b_next;
    logic          w_inc_next;
    logic          w_web_next;
    logic          w_gnta_next;
    logic          w_gntb_next;
    logic [DW-1:0] w_data_next;
    logic [AW-1:0] w_addr_next;
    logic [CW-1:0] w_count_next;
    logic          w_full_next;
    logic          w_done_next;

    // A wins when it is alone or when B was the last one served.
    assign w_pick_a = ReqA && (!ReqB || r_last_b);

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_last_b   <= 1'b1;
            IncB       <= 1'b1;
            WEB        <= 1'b0;
            GntA       <= 1'b0;
            GntB       <= 1'b0;
            DataInB    <= '0;
            AddrMirror <= '0;
            Count      <= '0;
            Full       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_last_b   <= w_last_b_next;
            IncB       <= w_inc_next;
            WEB        <= w_web_next;
            GntA       <= w_gnta_next;
            GntB       <= w_gntb_next;
            DataInB    <= w_data_next;
            AddrMirror <= w_addr_next;
            Count      <= w_count_next;
            Full       <= w_full_next;
            Done       <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Flush)              w_state_next = S_CLEAR;
                else if (ReqA || ReqB)  w_state_next = S_WRITE;
            end
            S_WRITE: begin
                if (Count == CW'(DEPTH - 1)) w_state_next = S_FULL;
                else                         w_state_next = S_IDLE;
            end
            S_FULL: begin
                if (Flush) w_state_next = S_CLEAR;
            end
            S_CLEAR: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered: compute the values for the state being entered,
    // plus the bookkeeping performed on the edge that leaves WRITE or CLEAR.
    always_comb begin
        w_last_b_next = r_last_b;
        w_inc_next    = 1'b1;
        w_web_next    = 1'b0;
        w_gnta_next   = 1'b0;
        w_gntb_next   = 1'b0;
        w_data_next   = DataInB;
        w_addr_next   = AddrMirror;
        w_count_next  = Count;
        w_full_next   = Full;
        w_done_next   = 1'b0;

        case (w_state_next)
            S_WRITE: begin
                w_inc_next    = 1'b0;
                w_web_next    = 1'b1;
                w_gnta_next   = w_pick_a;
                w_gntb_next   = !w_pick_a;
                w_data_next   = w_pick_a ? DataA : DataB;
                w_last_b_next = !w_pick_a;
            end
            S_CLEAR: begin
                w_inc_next = 1'b0;
                w_web_next = 1'b0;
            end
            default: ;
        endcase

        case (r_state)
            S_WRITE: begin
                w_addr_next  = (AddrMirror == AW'(DEPTH - 1)) ? '0 : AddrMirror + AW'(1);
                w_count_next = Count + CW'(1);
                w_full_next  = (Count == CW'(DEPTH - 1));
            end
            S_CLEAR: begin
                w_addr_next  = '0;
                w_count_next = '0;
                w_full_next  = 1'b0;
                w_done_next  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_b_sched.sv
// Bench for mc_b_sched: directed scenarios then randomized requesters/flush,
// all checked against a transaction-level model of the bank scheduler.
module tb_mc_b_sched;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          Reset = 1'b0;
    logic          ReqA  = 1'b0;
    logic          ReqB  = 1'b0;
    logic          Flush = 1'b0;
    logic [DW-1:0] DataA = '0;
    logic [DW-1:0] DataB = '0;
    logic          GntA, GntB, IncB, WEB, Full, Done;
    logic [DW-1:0] DataInB;
    logic [1:0]    AddrMirror;
    logic [2:0]    Count;

    mc_b_sched #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .Reset      (Reset),
        .ReqA       (ReqA),
        .DataA      (DataA),
        .ReqB       (ReqB),
        .DataB      (DataB),
        .Flush      (Flush),
        .GntA       (GntA),
        .GntB       (GntB),
        .IncB       (IncB),
        .WEB        (WEB),
        .DataInB    (DataInB),
        .AddrMirror (AddrMirror),
        .Count      (Count),
        .Full       (Full),
        .Done       (Done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a write in flight (owner), a clear in flight, fill level and address.
    int            m_fill;
    int            m_addr;
    bit            m_last_b;
    int            m_wr;      // -1 none, 0 = A writing, 1 = B writing
    bit            m_clr;
    bit            m_done;
    logic [DW-1:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill   = 0;
        m_addr   = 0;
        m_last_b = 1'b1;
        m_wr     = -1;
        m_clr    = 1'b0;
        m_done   = 1'b0;
        m_data   = '0;
    endtask

    task automatic model_edge(input bit a, input bit b, input bit f,
                              input logic [DW-1:0] da, input logic [DW-1:0] db);
        m_done = 1'b0;
        if (m_wr >= 0) begin
            m_fill = m_fill + 1;
            m_addr = (m_addr + 1) % DEPTH;
            m_wr   = -1;
        end else if (m_clr) begin
            m_fill = 0;
            m_addr = 0;
            m_done = 1'b1;
            m_clr  = 1'b0;
        end else if (f) begin
            m_clr = 1'b1;
        end else if (m_fill < DEPTH && (a || b)) begin
            if (a && (!b || m_last_b)) begin
                m_wr = 0; m_last_b = 1'b0; m_data = da;
            end else begin
                m_wr = 1; m_last_b = 1'b1; m_data = db;
            end
        end
    endtask

    task automatic check_outputs();
        check("WEB",        WEB,        (m_wr >= 0));
        check("IncB",       IncB,       (m_wr < 0) && !m_clr);
        check("GntA",       GntA,       (m_wr == 0));
        check("GntB",       GntB,       (m_wr == 1));
        check("DataInB",    DataInB,    m_data);
        check("AddrMirror", AddrMirror, m_addr);
        check("Count",      Count,      m_fill);
        check("Full",       Full,       (m_fill == DEPTH));
        check("Done",       Done,       m_done);
    endtask

    task automatic step();
        bit a, b, f;
        logic [DW-1:0] da, db;
        a = ReqA; b = ReqB; f = Flush; da = DataA; db = DataB;
        @(posedge clock);
        model_edge(a, b, f, da, db);
        #1;
        check_outputs();
        if (GntA || GntB)
            $display("[TB] write %s data=%02h addr=%0d", GntA ? "A" : "B", DataInB, AddrMirror);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_IncB"},  IncB,  1'b1);
        check({tag, "_WEB"},   WEB,   1'b0);
        check({tag, "_GntA"},  GntA,  1'b0);
        check({tag, "_GntB"},  GntB,  1'b0);
        check({tag, "_Count"}, Count, 3'd0);
        check({tag, "_Full"},  Full,  1'b0);
        check({tag, "_Addr"},  AddrMirror, 2'd0);
    endtask

    task automatic pulse_reset();
        #2 Reset = 1'b0;
        #1 check_reset_values("rst_async");
        model_reset();
        @(negedge clock);
        Reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #12 check_reset_values("rst_hold");
        check("rst_DataInB", DataInB, 8'h00);
        check("rst_Done",    Done,    1'b0);
        #10 Reset = 1'b1;

        // Idle for 5 cycles
        for (int i = 0; i < 5; i++) step();
        check_reset_values("idle");

        // Single-shot A
        ReqA = 1'b1; DataA = 8'h11;
        step();
        check("single_GntA", GntA, 1'b1);
        check("single_Data", DataInB, 8'h11);
        ReqA = 1'b0;
        step();
        check("single_Count", Count, 3'd1);
        check("single_Addr",  AddrMirror, 2'd1);

        // Both requesting: alternate A,B,A,B until full
        pulse_reset();
        ReqA = 1'b1; DataA = 8'hAA; ReqB = 1'b1; DataB = 8'hBB;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i % 2 == 0) begin
                check("alt_GntA", GntA, (i % 4 == 0));
                check("alt_Data", DataInB, (i % 4 == 0) ? 8'hAA : 8'hBB);
            end
        end
        check("full_Full",  Full, 1'b1);
        check("full_Count", Count, 3'd4);
        check("full_Addr",  AddrMirror, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_noGnt", GntA | GntB, 1'b0);
        end

        // Flush from FULL
        ReqA = 1'b0; ReqB = 1'b0; Flush = 1'b1;
        step();
        check("clr_IncB", IncB, 1'b0);
        check("clr_WEB",  WEB,  1'b0);
        step();
        check("clr_Done", Done, 1'b1);
        check("clr_Full", Full, 1'b0);
        Flush = 1'b0; ReqB = 1'b1; DataB = 8'h5C;
        step();
        check("post_clr_GntB", GntB, 1'b1);
        ReqB = 1'b0;
        step();

        // Count=2, Flush and ReqA together: clear wins
        ReqA = 1'b1; DataA = 8'h21;
        step();
        ReqA = 1'b0;
        step();
        check("pre_race_Count", Count, 3'd2);
        Flush = 1'b1; ReqA = 1'b1; DataA = 8'h3C;
        step();
        check("race_noGntA", GntA, 1'b0);
        step();
        check("race_Done", Done, 1'b1);
        Flush = 1'b0;
        step();
        check("race_GntA", GntA, 1'b1);
        check("race_Addr0", AddrMirror, 2'd0);
        ReqA = 1'b0;
        step();
        check("race_Addr1", AddrMirror, 2'd1);

        // Reset during a WRITE with Count=3
        for (int i = 0; i < 2; i++) begin
            ReqB = 1'b1; DataB = 8'(i + 1);
            step();
            ReqB = 1'b0;
            step();
        end
        check("mid_Count3", Count, 3'd3);
        ReqA = 1'b1; ReqB = 1'b1; DataA = 8'h7A; DataB = 8'h7B;
        step();
        check("mid_WEB", WEB, 1'b1);
        pulse_reset();
        step();
        check("mid_after_GntA", GntA, 1'b1);
        check("mid_after_Data", DataInB, 8'h7A);
        ReqA = 1'b0;

        // Randomized requesters and flush
        for (int c = 0; c < 800; c++) begin
            step();
            if (GntA || ($urandom_range(0, 63) == 0)) ReqA = 1'b0;
            else if (!ReqA && $urandom_range(0, 3) == 0) begin ReqA = 1'b1; DataA = 8'($urandom); end
            if (GntB || ($urandom_range(0, 63) == 0)) ReqB = 1'b0;
            else if (!ReqB && $urandom_range(0, 3) == 0) begin ReqB = 1'b1; DataB = 8'($urandom); end
            if (Done) Flush = 1'b0;
            else if (!Flush && $urandom_range(0, 19) == 0) Flush = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
